// File: rtl/tug_light_bar_pkg.sv
// rtl/tug_light_bar_pkg.sv - shared types and helpers for the tug-of-war light bar
// Purpose: round state encoding and the centre-light reset pattern.
// Contents: tug_state_t (PLAY/OVER), centre_onehot(n).
package tug_pkg;

   typedef enum logic {PLAY, OVER} tug_state_t;

   // One-hot pattern with only the middle light of an n-light bar set.
   // Returned wide; callers truncate to their bar length.
   function automatic logic [63:0] centre_onehot(input int n);
      centre_onehot = 64'd1 << ((n - 1) / 2);
   endfunction

endpackage

// File: rtl/tug_light_bar_edge_pulse.sv
// rtl/tug_light_bar_edge_pulse.sv - rising-edge detector for one key input
// Purpose: one-cycle high on pulse_o for each 0->1 transition of d_i.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-low reset
//   d_i     in  synchronised level input
//   pulse_o out d_i & ~(d_i delayed one cycle)
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic pulse_o
);

   logic d_q;

   // History resets to 1 so a key held through reset is not seen as a press.
   always_ff @(posedge clk) begin
      if (!reset) begin
         d_q <= 1'b1;
      end else begin
         d_q <= d_i;
      end
   end

   assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/tug_light_bar.sv
// rtl/tug_light_bar.sv - tug-of-war playfield: light position, round FSM, scores
// Purpose: one-hot light bar stepped by L/R presses; stepping off an end wins.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   L, R         in   synchronised player keys (levels)
//   restart      in   recentre light and enter PLAY, scores kept
//   lights       out  one-hot position (MSB = leftmost), zero in OVER
//   game_over    out  high while in OVER
//   left_win     out  one-cycle pulse when left wins
//   right_win    out  one-cycle pulse when right wins
//   left_score   out  saturating left win count
//   right_score  out  saturating right win count
module tug_light_bar
   import tug_pkg::*;
#(
   parameter int NUM_LIGHTS   = 9,
   parameter int SCORE_W      = 3,
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  L,
   input  logic                  R,
   input  logic                  restart,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic                  game_over,
   output logic                  left_win,
   output logic                  right_win,
   output logic [SCORE_W-1:0]    left_score,
   output logic [SCORE_W-1:0]    right_score
);

   localparam logic [NUM_LIGHTS-1:0] CENTRE_ONEHOT = NUM_LIGHTS'(centre_onehot(NUM_LIGHTS));
   localparam logic [SCORE_W-1:0]    SCORE_MAX     = '1;

   tug_state_t            state_q, state_d;
   logic [NUM_LIGHTS-1:0] lights_q, lights_d;
   logic                  left_win_q, left_win_d;
   logic                  right_win_q, right_win_d;
   logic [SCORE_W-1:0]    left_score_q, left_score_d;
   logic [SCORE_W-1:0]    right_score_q, right_score_d;
   logic                  press_l, press_r;

   edge_pulse u_edge_l (
      .clk     (clk),
      .reset   (reset),
      .d_i     (L),
      .pulse_o (press_l)
   );

   edge_pulse u_edge_r (
      .clk     (clk),
      .reset   (reset),
      .d_i     (R),
      .pulse_o (press_r)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= PLAY;
         lights_q      <= CENTRE_ONEHOT;
         left_win_q    <= 1'b0;
         right_win_q   <= 1'b0;
         left_score_q  <= '0;
         right_score_q <= '0;
      end else begin
         state_q       <= state_d;
         lights_q      <= lights_d;
         left_win_q    <= left_win_d;
         right_win_q   <= right_win_d;
         left_score_q  <= left_score_d;
         right_score_q <= right_score_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      lights_d      = lights_q;
      left_win_d    = 1'b0;
      right_win_d   = 1'b0;
      left_score_d  = left_score_q;
      right_score_d = right_score_q;

      if (state_q == PLAY) begin
         if (restart) begin
            // Restart outranks any press seen in the same cycle.
            lights_d = CENTRE_ONEHOT;
         end else if (press_l && !press_r) begin
            if (lights_q[NUM_LIGHTS-1]) begin
               left_win_d   = 1'b1;
               left_score_d = (left_score_q == SCORE_MAX) ? left_score_q : left_score_q + 1'b1;
               lights_d     = '0;
               state_d      = OVER;
            end else begin
               lights_d = lights_q << 1;
            end
         end else if (press_r && !press_l) begin
            if (lights_q[0]) begin
               right_win_d   = 1'b1;
               right_score_d = (right_score_q == SCORE_MAX) ? right_score_q : right_score_q + 1'b1;
               lights_d      = '0;
               state_d       = OVER;
            end else begin
               lights_d = lights_q >> 1;
            end
         end
      end else begin
         // Presses are ignored while the round is over.
         if (restart || AUTO_RESTART) begin
            state_d  = PLAY;
            lights_d = CENTRE_ONEHOT;
         end
      end
   end

   assign lights      = lights_q;
   assign game_over   = (state_q == OVER);
   assign left_win    = left_win_q;
   assign right_win   = right_win_q;
   assign left_score  = left_score_q;
   assign right_score = right_score_q;

endmodule
